// File: rtl/store_buffer.sv
// Store buffer between the MEM-stage request port and a 32-word data memory.
// Optional store-to-load forwarding is enabled by defining STORE_FWD_EN.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req_valid,
    input  logic        i_req_write,
    input  logic [4:0]  i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_req_ready,
    output logic [31:0] o_rdata,
    output logic        o_rdata_valid,
    output logic        o_empty,
    output logic        o_dm_memRead,
    output logic        o_dm_memWrite,
    output logic [4:0]  o_dm_address,
    output logic [31:0] o_dm_writeData,
    input  logic [31:0] i_dm_memOut
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [4:0]       r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_rdata;
    logic             r_rdata_valid;

    logic             w_const_addr;
    logic             w_not_full;
    logic             w_match;
    logic             w_ready;
    logic             w_accept;
    logic             w_load_acc;
    logic             w_load_fwd;
    logic             w_enq;
    logic             w_port_read;
    logic             w_drain;
    logic [31:0]      w_load_data;

    assign w_const_addr = (i_req_addr[4:1] == 4'b1111);
    assign w_not_full   = (r_count < CNT_W'(DEPTH));

`ifdef STORE_FWD_EN
    logic [31:0] w_fwd_data;

    // Scan valid entries oldest to youngest so the youngest match wins.
    always_comb begin
        w_match    = 1'b0;
        w_fwd_data = 32'd0;
        for (int k = 0; k < DEPTH; k++) begin
            w_match    = w_match |
                         ((CNT_W'(k) < r_count) && (r_addr[r_head + PTR_W'(k)] == i_req_addr));
            w_fwd_data = ((CNT_W'(k) < r_count) && (r_addr[r_head + PTR_W'(k)] == i_req_addr)) ?
                         r_data[r_head + PTR_W'(k)] : w_fwd_data;
        end
    end

    assign w_load_fwd  = w_load_acc & w_match;
    assign w_load_data = w_load_fwd ? w_fwd_data : i_dm_memOut;
`else
    // Hit detection only: a matching load must wait for the drain.
    always_comb begin
        w_match = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            w_match = w_match |
                      ((CNT_W'(k) < r_count) && (r_addr[r_head + PTR_W'(k)] == i_req_addr));
        end
    end

    assign w_load_fwd  = 1'b0;
    assign w_load_data = i_dm_memOut;
`endif

    // Request readiness; stores to the constant words are swallowed even when full.
    always_comb begin
        w_ready = 1'b0;
        if (reset) begin
            w_ready = 1'b0;
        end else if (i_req_write) begin
            w_ready = w_const_addr | w_not_full;
        end else begin
`ifdef STORE_FWD_EN
            w_ready = w_not_full;
`else
            w_ready = w_not_full & ~w_match;
`endif
        end
    end

    assign w_accept    = i_req_valid & w_ready;
    assign w_load_acc  = w_accept & ~i_req_write;
    assign w_enq       = w_accept & i_req_write & ~w_const_addr;
    assign w_port_read = w_load_acc & ~w_load_fwd;
    assign w_drain     = ~reset & ~w_port_read & (r_count != CNT_W'(0));

    // Memory port arbitration: a non-forwarded load beats the drain.
    always_comb begin
        o_dm_address   = 5'd0;
        o_dm_writeData = 32'd0;
        if (w_port_read) begin
            o_dm_address   = i_req_addr;
            o_dm_writeData = 32'd0;
        end else if (w_drain) begin
            o_dm_address   = r_addr[r_head];
            o_dm_writeData = r_data[r_head];
        end else begin
            o_dm_address   = 5'd0;
            o_dm_writeData = 32'd0;
        end
    end

    assign o_dm_memRead  = w_port_read;
    assign o_dm_memWrite = w_drain;
    assign o_req_ready   = w_ready;
    assign o_empty       = (r_count == CNT_W'(0));
    assign o_rdata       = r_rdata;
    assign o_rdata_valid = r_rdata_valid;

    // Entry storage; contents need no reset because count gates validity.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_tail] <= i_req_addr;
            r_data[r_tail] <= i_req_wdata;
        end
    end

    // Pointers, occupancy and registered load result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head        <= PTR_W'(0);
            r_tail        <= PTR_W'(0);
            r_count       <= CNT_W'(0);
            r_rdata       <= 32'd0;
            r_rdata_valid <= 1'b0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_drain) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count       <= r_count + CNT_W'(w_enq) - CNT_W'(w_drain);
            r_rdata_valid <= w_load_acc;
            if (w_load_acc) begin
                r_rdata <= w_load_data;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus randomized
// traffic checked against an architectural memory / pending-store model.
module tb_store_buffer;

    localparam int DEPTH = 4;
`ifdef STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req_valid;
    logic        i_req_write;
    logic [4:0]  i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_req_ready;
    logic [31:0] o_rdata;
    logic        o_rdata_valid;
    logic        o_empty;
    logic        o_dm_memRead;
    logic        o_dm_memWrite;
    logic [4:0]  o_dm_address;
    logic [31:0] o_dm_writeData;
    logic [31:0] i_dm_memOut;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_req_valid    (i_req_valid),
        .i_req_write    (i_req_write),
        .i_req_addr     (i_req_addr),
        .i_req_wdata    (i_req_wdata),
        .o_req_ready    (o_req_ready),
        .o_rdata        (o_rdata),
        .o_rdata_valid  (o_rdata_valid),
        .o_empty        (o_empty),
        .o_dm_memRead   (o_dm_memRead),
        .o_dm_memWrite  (o_dm_memWrite),
        .o_dm_address   (o_dm_address),
        .o_dm_writeData (o_dm_writeData),
        .i_dm_memOut    (i_dm_memOut)
    );

    // Data memory device: words 30/31 are read-only constants 1.
    logic [31:0] tb_mem [32];
    assign i_dm_memOut = (o_dm_address >= 5'd30) ? 32'd1 : tb_mem[o_dm_address];
    always @(posedge clk) begin
        if (o_dm_memWrite && (o_dm_address < 5'd30)) tb_mem[o_dm_address] <= o_dm_writeData;
    end

    // Reference model: architectural memory (program order), memory as drained,
    // and the FIFO of stores not yet written.
    typedef struct packed { logic [4:0] a; logic [31:0] d; } st_t;
    st_t         pend [$];
    logic [31:0] arch_mem [32];
    logic [31:0] dm_model [32];

    logic        exp_ready, exp_rd, exp_wr, exp_rvalid;
    logic [4:0]  exp_addr;
    logic [31:0] exp_wdata, exp_rdata;
    logic        c_w, c_rst, c_acc;
    logic [4:0]  c_a;
    logic [31:0] c_d;

    int n_checks = 0;
    int n_errors = 0;

    function automatic bit pend_has(input logic [4:0] a);
        foreach (pend[i]) if (pend[i].a == a) return 1'b1;
        return 1'b0;
    endfunction

    // Apply one request, predict this cycle's combinational outputs, wait to negedge.
    task automatic cycle(input bit v, input bit w, input logic [4:0] a,
                         input logic [31:0] d, input bit rst);
        bit ld, hit;
        reset = rst; i_req_valid = v; i_req_write = w; i_req_addr = a; i_req_wdata = d;
        if (rst) exp_ready = 1'b0;
        else if (w) exp_ready = (a >= 5'd30) || (pend.size() < DEPTH);
        else exp_ready = (pend.size() < DEPTH) && (FWD || !pend_has(a));
        c_acc = v && exp_ready;
        ld    = c_acc && !w;
        hit   = FWD && ld && pend_has(a);
        exp_rd    = ld && !hit;
        exp_wr    = !rst && !exp_rd && (pend.size() > 0);
        exp_addr  = exp_rd ? a : (exp_wr ? pend[0].a : 5'd0);
        exp_wdata = exp_wr ? pend[0].d : 32'd0;
        c_w = w; c_a = a; c_d = d; c_rst = rst;
        @(negedge clk);
    endtask

    // Advance the clock edge and the reference model together.
    task automatic commit();
        @(posedge clk);
        if (c_rst) begin
            pend.delete();
            arch_mem   = dm_model;
            exp_rvalid = 1'b0;
            exp_rdata  = 32'd0;
        end else begin
            if (exp_wr) begin
                dm_model[pend[0].a] = pend[0].d;
                void'(pend.pop_front());
            end
            if (c_acc && c_w && (c_a < 5'd30)) begin
                pend.push_back('{a: c_a, d: c_d});
                arch_mem[c_a] = c_d;
            end
            if (c_acc && !c_w) begin
                exp_rvalid = 1'b1;
                exp_rdata  = (c_a >= 5'd30) ? 32'd1 : arch_mem[c_a];
            end else begin
                exp_rvalid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        commit();
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1); commit();
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        if (o_empty !== 1'b1) begin n_errors++; $display("FAIL reset.empty got %0b want 1", o_empty); end
        n_checks++;
        if (o_rdata_valid !== 1'b0) begin n_errors++; $display("FAIL reset.rvalid got %0b want 0", o_rdata_valid); end
        n_checks++;
        if (o_rdata !== 32'd0) begin n_errors++; $display("FAIL reset.rdata got %h want 0", o_rdata); end
        n_checks++;
        if ({o_dm_memRead, o_dm_memWrite} !== 2'b00) begin
            n_errors++; $display("FAIL reset.dm got %b want 00", {o_dm_memRead, o_dm_memWrite});
        end
        n_checks++;
        commit();
    endtask

    task automatic test_store_load();
        cycle(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        if (o_req_ready !== 1'b1) begin n_errors++; $display("FAIL st5.ready got %0b want 1", o_req_ready); end
        n_checks++;
        commit();
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        if ({o_dm_memWrite, o_dm_address, o_dm_writeData} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            n_errors++;
            $display("FAIL st5.drain got wr=%0b a=%0d d=%h want wr=1 a=5 d=deadbeef",
                     o_dm_memWrite, o_dm_address, o_dm_writeData);
        end
        n_checks++;
        if (o_empty !== 1'b0) begin n_errors++; $display("FAIL st5.busy got %0b want 0", o_empty); end
        n_checks++;
        commit();
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        if (o_empty !== 1'b1) begin n_errors++; $display("FAIL st5.empty got %0b want 1", o_empty); end
        n_checks++;
        commit();
        cycle(1'b1, 1'b0, 5'd5, 32'd0, 1'b0);
        if ({o_req_ready, o_dm_memRead, o_dm_address} !== {1'b1, 1'b1, 5'd5}) begin
            n_errors++; $display("FAIL ld5.port got rdy=%0b rd=%0b a=%0d want 1 1 5",
                                 o_req_ready, o_dm_memRead, o_dm_address);
        end
        n_checks++;
        commit();
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        if ({o_rdata_valid, o_rdata} !== {1'b1, 32'hDEADBEEF}) begin
            n_errors++; $display("FAIL ld5.data got v=%0b d=%h want v=1 d=deadbeef", o_rdata_valid, o_rdata);
        end
        n_checks++;
        commit();
    endtask

    task automatic test_same_addr();
        int  stalls = 0;
        bit  got    = 1'b0;
        cycle(1'b1, 1'b1, 5'd3, 32'h11, 1'b0); commit();
        cycle(1'b1, 1'b1, 5'd3, 32'h22, 1'b0); commit();
        for (int i = 0; i < 10 && !got; i++) begin
            cycle(1'b1, 1'b0, 5'd3, 32'd0, 1'b0);
            if (o_req_ready === 1'b1) begin
                got = 1'b1;
                if (o_dm_memRead !== !FWD) begin
                    n_errors++; $display("FAIL same3.memread got %0b want %0b", o_dm_memRead, !FWD);
                end
                n_checks++;
            end else begin
                stalls++;
            end
            commit();
        end
        if (!got) begin n_errors++; $display("FAIL same3.timeout got no accept want accept"); end
        n_checks++;
        if (stalls != (FWD ? 0 : 1)) begin
            n_errors++; $display("FAIL same3.stalls got %0d want %0d", stalls, FWD ? 0 : 1);
        end
        n_checks++;
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        if ({o_rdata_valid, o_rdata} !== {1'b1, 32'h22}) begin
            n_errors++; $display("FAIL same3.data got v=%0b d=%h want v=1 d=22", o_rdata_valid, o_rdata);
        end
        n_checks++;
        commit();
    endtask

    task automatic test_const_addr();
        cycle(1'b1, 1'b1, 5'd31, 32'hFFFF, 1'b0);
        if (o_req_ready !== 1'b1) begin n_errors++; $display("FAIL c31.ready got %0b want 1", o_req_ready); end
        n_checks++;
        commit();
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        if ({o_empty, o_dm_memWrite} !== 2'b10) begin
            n_errors++; $display("FAIL c31.dropped got empty=%0b wr=%0b want 1 0", o_empty, o_dm_memWrite);
        end
        n_checks++;
        commit();
        cycle(1'b1, 1'b0, 5'd31, 32'd0, 1'b0); commit();
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        if ({o_rdata_valid, o_rdata} !== {1'b1, 32'd1}) begin
            n_errors++; $display("FAIL c31.data got v=%0b d=%h want v=1 d=1", o_rdata_valid, o_rdata);
        end
        n_checks++;
        commit();
    endtask

    task automatic test_no_false_match();
        cycle(1'b1, 1'b1, 5'd11, 32'hABCD, 1'b0); commit();
        cycle(1'b1, 1'b0, 5'd10, 32'd0, 1'b0);
        if ({o_req_ready, o_dm_memRead, o_dm_memWrite, o_dm_address} !== {1'b1, 1'b1, 1'b0, 5'd10}) begin
            n_errors++; $display("FAIL nm.load got rdy=%0b rd=%0b wr=%0b a=%0d want 1 1 0 10",
                                 o_req_ready, o_dm_memRead, o_dm_memWrite, o_dm_address);
        end
        n_checks++;
        commit();
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        if ({o_rdata_valid, o_rdata} !== {1'b1, 32'd0}) begin
            n_errors++; $display("FAIL nm.data got v=%0b d=%h want v=1 d=0", o_rdata_valid, o_rdata);
        end
        n_checks++;
        if ({o_dm_memWrite, o_dm_address} !== {1'b1, 5'd11}) begin
            n_errors++; $display("FAIL nm.drain got wr=%0b a=%0d want 1 11", o_dm_memWrite, o_dm_address);
        end
        n_checks++;
        commit();
    endtask

    task automatic test_reset_pending();
        cycle(1'b1, 1'b0, 5'd9, 32'd0, 1'b0); commit();
        cycle(1'b1, 1'b1, 5'd20, 32'h5555, 1'b0); commit();
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        if (o_dm_memWrite !== 1'b0) begin n_errors++; $display("FAIL rp.nowrite got %0b want 0", o_dm_memWrite); end
        n_checks++;
        commit();
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        if ({o_empty, o_dm_memWrite, o_rdata_valid} !== 3'b100) begin
            n_errors++; $display("FAIL rp.state got empty=%0b wr=%0b v=%0b want 1 0 0",
                                 o_empty, o_dm_memWrite, o_rdata_valid);
        end
        n_checks++;
        commit();
        idle(); idle();
        if (tb_mem[20] !== 32'd0) begin n_errors++; $display("FAIL rp.discard got %h want 0", tb_mem[20]); end
        n_checks++;
    endtask

    task automatic test_fill();
        logic [31:0] golden [DEPTH];
        for (int i = 0; i < 2 * DEPTH; i++) begin
            if (i % 2 == 0) begin
                golden[i/2] = $urandom();
                cycle(1'b1, 1'b1, 5'(12 + i/2), golden[i/2], 1'b0);
            end else begin
                cycle(1'b1, 1'b0, 5'($urandom_range(12, 15)), 32'd0, 1'b0);
            end
            if ({o_req_ready, o_dm_memRead, o_dm_memWrite} !== {exp_ready, exp_rd, exp_wr}) begin
                n_errors++; $display("FAIL fill.port[%0d] got %b want %b", i,
                                     {o_req_ready, o_dm_memRead, o_dm_memWrite}, {exp_ready, exp_rd, exp_wr});
            end
            n_checks++;
            if (exp_rvalid && (o_rdata !== exp_rdata)) begin
                n_errors++; $display("FAIL fill.rdata[%0d] got %h want %h", i, o_rdata, exp_rdata);
            end
            n_checks++;
            commit();
        end
        for (int i = 0; i < 2 * DEPTH; i++) idle();
        for (int k = 0; k < DEPTH; k++) begin
            if (tb_mem[12 + k] !== golden[k]) begin
                n_errors++; $display("FAIL fill.mem[%0d] got %h want %h", 12 + k, tb_mem[12 + k], golden[k]);
            end
            n_checks++;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [4:0] a;
            a = ($urandom_range(0, 9) == 0) ? 5'(30 + $urandom_range(0, 1)) : 5'($urandom_range(0, 7));
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, $urandom(), 1'b0);
            if (o_req_ready !== exp_ready) begin
                n_errors++; $display("FAIL rnd.ready[%0d] got %0b want %0b", n, o_req_ready, exp_ready);
            end
            n_checks++;
            if ({o_dm_memRead, o_dm_memWrite} !== {exp_rd, exp_wr}) begin
                n_errors++; $display("FAIL rnd.port[%0d] got %b want %b", n,
                                     {o_dm_memRead, o_dm_memWrite}, {exp_rd, exp_wr});
            end
            n_checks++;
            if ((exp_rd || exp_wr) && (o_dm_address !== exp_addr)) begin
                n_errors++; $display("FAIL rnd.addr[%0d] got %0d want %0d", n, o_dm_address, exp_addr);
            end
            n_checks++;
            if (exp_wr && (o_dm_writeData !== exp_wdata)) begin
                n_errors++; $display("FAIL rnd.wdata[%0d] got %h want %h", n, o_dm_writeData, exp_wdata);
            end
            n_checks++;
            if (o_empty !== (pend.size() == 0)) begin
                n_errors++; $display("FAIL rnd.empty[%0d] got %0b want %0b", n, o_empty, pend.size() == 0);
            end
            n_checks++;
            if (o_rdata_valid !== exp_rvalid) begin
                n_errors++; $display("FAIL rnd.rvalid[%0d] got %0b want %0b", n, o_rdata_valid, exp_rvalid);
            end
            n_checks++;
            if (exp_rvalid && (o_rdata !== exp_rdata)) begin
                n_errors++; $display("FAIL rnd.rdata[%0d] got %h want %h", n, o_rdata, exp_rdata);
            end
            n_checks++;
            commit();
        end
        for (int i = 0; i < 2 * DEPTH; i++) idle();
        for (int k = 0; k < 30; k++) begin
            if (tb_mem[k] !== arch_mem[k]) begin
                n_errors++; $display("FAIL rnd.mem[%0d] got %h want %h", k, tb_mem[k], arch_mem[k]);
            end
            n_checks++;
        end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) begin
            tb_mem[k]   = 32'd0;
            arch_mem[k] = 32'd0;
            dm_model[k] = 32'd0;
        end
        exp_rvalid = 1'b0;
        exp_rdata  = 32'd0;
        test_reset();
        test_store_load();
        test_same_addr();
        test_const_addr();
        test_no_false_match();
        test_reset_pending();
        test_fill();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
